pixel_sink: RTL and testbench
=============================

# pixel_sink

Receiving end of the plot interface that `display` drives. Accepts (x, y, colour) pixel writes with a plot strobe, buffers them in a small FIFO and commits them to the external 160x120 3-bit frame-buffer RAM feeding the VGA adapter. Also provides a full-screen clear sweep. Sits between the drawing logic and the frame-buffer write port.

## Interface
- `WIDTH`, default 160: visible columns.
- `HEIGHT`, default 120: visible rows.
- `FIFO_DEPTH`, default 8: pixel FIFO entries; power of two.
- `BG_COLOUR`, default 3'b000: colour written by a clear sweep.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous reset, active-high.
- `x` in 8: pixel column.
- `y` in 7: pixel row.
- `colour` in 3: pixel colour, RGB, MSB is red.
- `plot` in 1: a pixel is offered this cycle.
- `ready` out 1: the FIFO can accept a pixel this cycle.
- `clear` in 1: one-cycle request to start a clear sweep.
- `busy` out 1: high while a clear sweep runs or the FIFO is non-empty.
- `mem_addr` out 15: frame-buffer write address, computed as y*WIDTH + x.
- `mem_data` out 3: frame-buffer write data.
- `mem_we` out 1: frame-buffer write enable.
- `overflow` out 1: sticky. Set when `plot` arrives while `ready` is low.
- `oob_count` out 8: saturating count of out-of-range pixels that were discarded.

## Operation
- Transfer happens when `plot && ready`. `ready` = FIFO not full, and does not depend on `plot`.
- `plot && !ready`:
  - The pixel is dropped and `overflow` is set.
  - `overflow` stays set until reset.
  - The producer is not required to hold its inputs.
- Range check is done at acceptance.
  - A pixel with x >= WIDTH or y >= HEIGHT is not enqueued.
  - Such a pixel increments `oob_count`, which saturates at 255.
  - An out-of-range pixel does not consume FIFO space.
- Address arithmetic:
  - y*160 = (y<<7) + (y<<5), computed in 15 bits.
  - Maximum address is 19199. No wrap is possible for in-range pixels.
- FSM states:
  - IDLE to DRAIN when the FIFO is non-empty.
  - IDLE to CLEAR on `clear`.
  - DRAIN pops one entry per cycle and issues one write per cycle.
  - DRAIN to IDLE when the FIFO is empty after the pop.
  - DRAIN to CLEAR on `clear`. The FIFO contents are retained and drained after the sweep.
  - CLEAR writes `BG_COLOUR` to addresses 0..WIDTH*HEIGHT-1, one address per cycle.
  - CLEAR leaves on the cycle after address 19199 is written: to DRAIN if the FIFO is non-empty, otherwise to IDLE.
- `clear` while in CLEAR is ignored; the sweep does not restart.
- `plot` and `clear` in the same cycle: the pixel is enqueued first and committed after the sweep, so it survives the clear.
- A new plot accepted while in DRAIN is enqueued normally. Simultaneous push and pop keeps the FIFO occupancy unchanged.

## Timing
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - `ready`=1, `busy`=0, `overflow`=0, `oob_count`=0.
  - FIFO empty, FSM in IDLE, sweep counter 0.
- Reset mid-sweep or mid-drain: the operation is aborted and the FIFO is flushed. Frame-buffer contents are left as they are.
- All memory outputs are registered.
- Latency: a pixel accepted at edge N with the FIFO empty and the FSM in IDLE appears as `mem_we`=1 with the correct address and data in cycle N+1.
- Throughput: one write per cycle, sustained.
- Clear duration: 19200 cycles with `mem_we` high, starting the cycle after `clear` is sampled.
- `mem_we` is low in every cycle that has no write. `mem_addr` and `mem_data` hold their last values when `mem_we` is low.
- `busy` is registered. It is high from the cycle after any accept or clear start until the cycle after the last write.

## Structure
- Shared package `starflux_pkg` holds:
  - `SCREEN_W` = 160, `SCREEN_H` = 120, `FB_ADDR_W` = 15.
  - Colour constants `RED`=100, `GREEN`=010, `BLUE`=001, `BLACK`=000.
  - The FSM state enum.
- Sub-module `pixel_fifo`: synchronous FIFO, 18-bit entries {x, y, colour}, with full/empty and count outputs.
- Address multiply, range check and FSM live in the top level.

## Test plan
- Reset, then a single plot of x=5, y=2, colour=100: next cycle `mem_we`=1, `mem_addr`=325, `mem_data`=100; then `busy` falls.
- Plot x=160, y=0, then x=0, y=120: no writes, `oob_count`=2, `ready` stays 1.
- Ten back-to-back plots with depth 8 during a clear:
  - `ready` goes low after 8 plots, the 9th sets `overflow`.
  - After 19200 BG writes, exactly 8 pixel writes occur in order.
- `clear` and plot x=159, y=119 in the same cycle: 19200 writes of 000 to addresses 0..19199, then a write to address 19199 with the plotted colour.
- `clear` pulsed again at sweep address 1000: the sweep is not restarted and the total sweep length is still 19200 cycles.
- Reset asserted mid-sweep: all outputs return to their reset values the next cycle and the FIFO is empty.

Source files
------------

// File: rtl/starflux_pkg.sv
// Shared screen geometry, colour constants and types for the plot path
// into the 160x120 3-bit frame buffer.
package starflux_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } sink_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    // y*160 as two shifts and an add; max 119*160 fits in 15 bits
    function automatic logic [FB_ADDR_W-1:0] row_base_160(input logic [6:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = {8'b0, y};
        return (yw << 7) + (yw << 5);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of {x, y, colour} entries; head is visible on dout
// whenever the FIFO is non-empty. Push when full and pop when empty are ignored.
module pixel_fifo
    import starflux_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  pixel_t                     din,
    output pixel_t                     dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pixel_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// Frame-buffer write side of the plot interface: range-checks and buffers
// pixels, commits them one per cycle, and runs full-screen clear sweeps.
module pixel_sink
    import starflux_pkg::*;
#(
    parameter int         WIDTH      = 160,
    parameter int         HEIGHT     = 120,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           x,
    input  logic [6:0]           y,
    input  logic [2:0]           colour,
    input  logic                 plot,
    output logic                 ready,
    input  logic                 clear,
    output logic                 busy,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [2:0]           mem_data,
    output logic                 mem_we,
    output logic                 overflow,
    output logic [7:0]           oob_count
);

    localparam int                   CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]           X_LIM     = 8'(WIDTH);
    localparam logic [6:0]           Y_LIM     = 7'(HEIGHT);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WIDTH * HEIGHT - 1);

    sink_state_t          state;
    logic [FB_ADDR_W-1:0] sweep_cnt;

    pixel_t               in_pix;
    pixel_t               head;
    pixel_t               src;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_after;

    logic                 in_range;
    logic                 accept;
    logic                 push;
    logic                 draining;
    logic                 bypass;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 src_valid;
    logic [FB_ADDR_W-1:0] src_y_w;
    logic [FB_ADDR_W-1:0] src_addr;

    assign ready    = !full;
    assign in_pix   = '{x: x, y: y, colour: colour};
    assign in_range = (x < X_LIM) && (y < Y_LIM);
    assign accept   = plot && ready;
    assign push     = accept && in_range;

    // The write port serves pixels only outside a sweep and when no sweep starts now.
    // With the FIFO empty, an incoming pixel skips the FIFO to meet one-cycle latency.
    assign draining  = (state != ST_CLEAR) && !clear;
    assign bypass    = draining && empty && push;
    assign fifo_push = push && !bypass;
    assign fifo_pop  = draining && !empty;
    assign src_valid = fifo_pop || bypass;
    assign src       = empty ? in_pix : head;

    assign count_after = count + CW'(fifo_push) - CW'(fifo_pop);

    assign src_y_w  = {8'b0, src.y};
    assign src_addr = ((WIDTH == SCREEN_W) ? row_base_160(src.y)
                                           : src_y_w * FB_ADDR_W'(WIDTH))
                      + {7'b0, src.x};

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_pix),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sweep_cnt <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            oob_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (plot && !ready)
                overflow <= 1'b1;
            if (accept && !in_range && oob_count != 8'hFF)
                oob_count <= oob_count + 8'd1;

            case (state)
                ST_CLEAR: begin
                    mem_we   <= 1'b1;
                    mem_addr <= sweep_cnt;
                    mem_data <= BG_COLOUR;
                    busy     <= 1'b1;
                    if (sweep_cnt == LAST_ADDR) begin
                        sweep_cnt <= '0;
                        state     <= (count_after != '0) ? ST_DRAIN : ST_IDLE;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clear) begin
                        // address 0 is written on the entry edge, so the counter starts at 1
                        state     <= ST_CLEAR;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_data  <= BG_COLOUR;
                        sweep_cnt <= FB_ADDR_W'(1);
                        busy      <= 1'b1;
                    end else begin
                        if (src_valid) begin
                            mem_we   <= 1'b1;
                            mem_addr <= src_addr;
                            mem_data <= src.colour;
                        end
                        state <= (count_after != '0) ? ST_DRAIN : ST_IDLE;
                        busy  <= src_valid || (count_after != '0);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink: single plots, range rejects, clear sweeps
// with overflow, plot/clear collisions, clear re-pulse and mid-sweep reset.
module tb_pixel_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic        clear;
    logic        busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        overflow;
    logic [7:0]  oob_count;

    int checks = 0;
    int errors = 0;

    localparam int SWEEP = 19200;

    logic        collect = 1'b0;
    int          aq[$];
    int          dq[$];

    pixel_sink dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .ready     (ready),
        .clear     (clear),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .overflow  (overflow),
        .oob_count (oob_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (collect && mem_we) begin
            aq.push_back(int'(mem_addr));
            dq.push_back(int'(mem_data));
        end
    end

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!busy && !mem_we) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; plot = 1'b0; clear = 1'b0; x = '0; y = '0; colour = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_data !== 3'd0) begin
            errors++;
            $display("FAIL reset_mem: we=%b addr=%0d data=%b, required 0/0/000", mem_we, mem_addr, mem_data);
        end
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || oob_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_status: ready=%b busy=%b ovf=%b oob=%0d, required 1/0/0/0", ready, busy, overflow, oob_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_plot();
        x = 8'd5; y = 7'd2; colour = 3'b100; plot = 1'b1;
        @(negedge clk);
        plot = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd325 || mem_data !== 3'b100) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d data=%b, required 1/325/100", mem_we, mem_addr, mem_data);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_hi: busy=%b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 15'd325 || mem_data !== 3'b100) begin
            errors++;
            $display("FAIL single_after: we=%b busy=%b addr=%0d data=%b, required 0/0/325/100", mem_we, busy, mem_addr, mem_data);
        end
    endtask

    task automatic test_oob();
        int writes = 0;
        int ready_low = 0;
        x = 8'd160; y = 7'd0; colour = 3'b010; plot = 1'b1;
        if (!ready) ready_low++;
        @(negedge clk);
        if (mem_we) writes++;
        x = 8'd0; y = 7'd120;
        if (!ready) ready_low++;
        @(negedge clk);
        if (mem_we) writes++;
        plot = 1'b0;
        if (!ready) ready_low++;
        @(negedge clk);
        if (mem_we) writes++;
        checks++;
        if (writes != 0) begin
            errors++;
            $display("FAIL oob_writes: %0d writes, required 0", writes);
        end
        checks++;
        if (oob_count !== 8'd2) begin
            errors++;
            $display("FAIL oob_count: %0d, required 2", oob_count);
        end
        checks++;
        if (ready_low != 0) begin
            errors++;
            $display("FAIL oob_ready: ready low in %0d cycles, required 0", ready_low);
        end
    endtask

    task automatic test_clear_overflow();
        bit to;
        int bad;
        logic exp_ready;
        aq.delete(); dq.delete();
        collect = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_ready = (i < 8);
            checks++;
            if (ready !== exp_ready) begin
                errors++;
                $display("FAIL ovf_ready_%0d: ready=%b, required %b", i, ready, exp_ready);
            end
            x = 8'(10 + i); y = 7'(i); colour = 3'(i + 1); plot = 1'b1;
            @(negedge clk);
        end
        plot = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: overflow=%b, required 1", overflow);
        end
        wait_idle(SWEEP + 100, to);
        collect = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL ovf_timeout: busy still high, required idle");
        end
        checks++;
        if (aq.size() != SWEEP + 8) begin
            errors++;
            $display("FAIL ovf_write_count: %0d writes, required %0d", aq.size(), SWEEP + 8);
        end else begin
            bad = 0;
            for (int a = 0; a < SWEEP; a++)
                if (aq[a] != a || dq[a] != 0) bad++;
            for (int i = 0; i < 8; i++)
                if (aq[SWEEP + i] != i * 160 + 10 + i || dq[SWEEP + i] != ((i + 1) % 8)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ovf_write_order: %0d wrong writes, required 0", bad);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_persist: overflow=%b, required 1", overflow);
        end
    endtask

    task automatic test_clear_and_plot();
        bit to;
        int bad;
        aq.delete(); dq.delete();
        collect = 1'b1;
        clear = 1'b1; plot = 1'b1; x = 8'd159; y = 7'd119; colour = 3'b110;
        @(negedge clk);
        clear = 1'b0; plot = 1'b0;
        wait_idle(SWEEP + 100, to);
        collect = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL cp_timeout: busy still high, required idle");
        end
        checks++;
        if (aq.size() != SWEEP + 1) begin
            errors++;
            $display("FAIL cp_write_count: %0d writes, required %0d", aq.size(), SWEEP + 1);
        end else begin
            bad = 0;
            for (int a = 0; a < SWEEP; a++)
                if (aq[a] != a || dq[a] != 0) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL cp_sweep: %0d wrong sweep writes, required 0", bad);
            end
            checks++;
            if (aq[SWEEP] != 19199 || dq[SWEEP] != 6) begin
                errors++;
                $display("FAIL cp_pixel: addr=%0d data=%0d, required 19199/6", aq[SWEEP], dq[SWEEP]);
            end
        end
    endtask

    task automatic test_clear_repulse();
        bit to;
        bit hit;
        int bad;
        aq.delete(); dq.delete();
        collect = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            if (mem_we && mem_addr == 15'd1000) hit = 1'b1;
            else @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rp_reach_1000: sweep address 1000 not seen, required seen");
        end
        wait_idle(SWEEP + 100, to);
        collect = 1'b0;
        checks++;
        if (to || aq.size() != SWEEP) begin
            errors++;
            $display("FAIL rp_length: %0d writes (timeout=%0d), required %0d", aq.size(), to, SWEEP);
        end else begin
            bad = 0;
            for (int a = 0; a < SWEEP; a++)
                if (aq[a] != a) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rp_sequence: %0d out-of-order addresses, required 0", bad);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int writes = 0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 8'(i); y = 7'(i); colour = 3'b001; plot = 1'b1;
            @(negedge clk);
        end
        plot = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_data !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_mem: we=%b addr=%0d data=%b, required 0/0/000", mem_we, mem_addr, mem_data);
        end
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || oob_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_status: ready=%b busy=%b ovf=%b oob=%0d, required 1/0/0/0", ready, busy, overflow, oob_count);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_we || busy) writes++;
        end
        checks++;
        if (writes != 0) begin
            errors++;
            $display("FAIL mid_reset_flush: %0d active cycles after reset, required 0", writes);
        end
    endtask

    initial begin
        test_reset();
        test_single_plot();
        test_oob();
        test_clear_overflow();
        test_clear_and_plot();
        test_clear_repulse();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
